mp_adder_ctrl: RTL

Multi-precision add/subtract sequencer built around a single N-bit `adder_parallel` datapath. It streams one WORDS×N-bit operation through the adder one word per cycle, least-significant word first. Between words it holds the inter-word carry in a register. It sits between an operand source and a result sink, both using valid/ready handshakes, and lets the ALU handle operands wider than its native adder.

---
 rtl/alu_pkg.sv | 12 +
 rtl/adder_parallel.sv | 14 +
 rtl/mp_adder_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared ALU definitions: sequencer state encoding and default datapath geometry.
package alu_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int N_DEF     = 8;
    localparam int WORDS_DEF = 4;
endpackage

// File: rtl/adder_parallel.sv
`timescale 1ns/1ps
// N-bit combinational adder with carry in/out.
// Zero latency, no flow control.
module adder_parallel #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/mp_adder_ctrl.sv
`timescale 1ns/1ps
// Multi-precision add/sub: streams WORDS x N-bit operands LSW first through one N-bit adder.
// One cycle operand-to-result latency; a stalled result drops op_ready so no word is ever lost.
module mp_adder_ctrl
    import alu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [N-1:0] a_word,
    input  logic [N-1:0] b_word,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_word,
    output logic         res_last,
    output logic         busy,
    output logic         done,
    output logic         carry_out,
    output logic         zero
);
    localparam int            CW   = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t        state, state_nxt;
    logic          sub_reg;
    logic          carry_reg;
    logic          zero_acc;
    logic [CW-1:0] count;
    logic [N-1:0]  b_eff;
    logic [N-1:0]  sum;
    logic          cout;
    logic          op_xfer;
    logic          res_xfer;
    logic          last_op;
    logic          sum_zero;

    // Subtraction is A + ~B + 1, the +1 coming from carry_reg seeded with sub.
    assign b_eff = sub_reg ? ~b_word : b_word;

    adder_parallel #(.N(N)) u_adder (
        .a    (a_word),
        .b    (b_eff),
        .cin  (carry_reg),
        .sum  (sum),
        .cout (cout)
    );

    assign op_ready = (state == RUN) && (!res_valid || res_ready);
    assign op_xfer  = op_valid && op_ready;
    assign res_xfer = res_valid && res_ready;
    assign last_op  = op_xfer && (count == LAST);
    assign sum_zero = (sum == '0);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_op) state_nxt = DRAIN;
            DRAIN:   if (res_xfer && res_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            zero_acc  <= 1'b0;
            count     <= '0;
            res_word  <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && res_xfer && res_last;
            if (state == IDLE && start) begin
                sub_reg   <= sub;
                carry_reg <= sub;
                count     <= '0;
                zero_acc  <= 1'b1;
            end
            if (op_xfer) begin
                res_word  <= sum;
                res_valid <= 1'b1;
                res_last  <= (count == LAST);
                count     <= count + CW'(1);
                carry_reg <= cout;
                zero_acc  <= zero_acc && sum_zero;
                if (count == LAST) begin
                    carry_out <= cout;
                    zero      <= zero_acc && sum_zero;
                end
            end else if (res_xfer) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule
